// File: rtl/alu_writeback_stage_pkg.sv
// Shared CPU definitions: write-back source encodings, flag bit positions and default widths.
package alu_writeback_stage_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 2;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_MEM   = 2'b01,
    WB_PC    = 2'b10,
    WB_FLAGS = 2'b11
  } wb_sel_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/alu_writeback_stage_flag_unit.sv
// Architectural flags {V,C,Z}, sticky overflow and saturating overflow counter.
module flag_unit
  import alu_writeback_stage_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_update,
  input  logic             i_v,
  input  logic             i_c,
  input  logic             i_z,
  input  logic             i_clear,
  output logic [2:0]       o_flags,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_count
);

  logic [2:0]       r_flags;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // An accepted overflow beats a simultaneous clear: the event restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags  <= '0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_update) begin
        r_flags[FLAG_V] <= i_v;
        r_flags[FLAG_C] <= i_c;
        r_flags[FLAG_Z] <= i_z;
      end
      if (i_update && i_v) begin
        r_sticky <= 1'b1;
        r_count  <= i_clear ? CNT_W'(1) : sat_inc(r_count);
      end else if (i_clear) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
      end
    end
  end

  assign o_flags  = r_flags;
  assign o_sticky = r_sticky;
  assign o_count  = r_count;

endmodule

// File: rtl/alu_writeback_stage.sv
// One-entry registered write-back stage after the ALU: write-back mux, branch
// resolution and valid/ready handshake; status flags live in flag_unit.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_W-1:0]     REZ,
  input  logic                  Zero,
  input  logic                  Overflow,
  input  logic                  CarryOut,
  input  logic [DATA_W-1:0]     MemData,
  input  logic [DATA_W-1:0]     PCPlus2,
  input  logic [1:0]            WbSel,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] DestReg,
  input  logic                  FlagWrite,
  input  logic                  Branch,
  input  logic                  BranchNE,
  input  logic [DATA_W-1:0]     BranchTarget,
  input  logic                  Flush,
  input  logic                  ClearSticky,
  input  logic                  OutReady,
  output logic                  OutValid,
  output logic                  WriteEn,
  output logic [REG_ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  BranchTaken,
  output logic [DATA_W-1:0]     BranchPC,
  output logic [2:0]            Flags,
  output logic                  StickyOverflow,
  output logic [CNT_W-1:0]      OverflowCount
);

  logic                  r_out_valid;
  logic                  r_regwrite;
  logic                  r_taken;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_bpc;
  logic                  w_accept;
  logic [DATA_W-1:0]     w_wb_data;
  logic [2:0]            w_flags;

  assign InReady  = !r_out_valid || OutReady;
  assign w_accept = InValid && InReady && !Flush;

  // The flag word reflects flags before this instruction's own update.
  always_comb begin
    w_wb_data = REZ;
    case (WbSel)
      WB_ALU:   w_wb_data = REZ;
      WB_MEM:   w_wb_data = MemData;
      WB_PC:    w_wb_data = PCPlus2;
      WB_FLAGS: w_wb_data = {{(DATA_W-3){1'b0}}, w_flags};
      default:  w_wb_data = REZ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_regwrite  <= 1'b0;
      r_taken     <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_bpc       <= '0;
    end else begin
      if (Flush)         r_out_valid <= 1'b0;
      else if (w_accept) r_out_valid <= 1'b1;
      else if (OutReady) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_regwrite <= RegWrite;
        r_taken    <= Branch && (Zero ^ BranchNE);
        r_waddr    <= DestReg;
        r_wdata    <= w_wb_data;
        r_bpc      <= BranchTarget;
      end
    end
  end

  flag_unit #(.CNT_W(CNT_W)) u_flag_unit (
    .clk      (Clock),
    .rst      (Reset),
    .i_update (w_accept && FlagWrite),
    .i_v      (Overflow),
    .i_c      (CarryOut),
    .i_z      (Zero),
    .i_clear  (ClearSticky),
    .o_flags  (w_flags),
    .o_sticky (StickyOverflow),
    .o_count  (OverflowCount)
  );

  assign OutValid    = r_out_valid;
  assign WriteEn     = r_out_valid && r_regwrite;
  assign WriteAddr   = r_waddr;
  assign WriteData   = r_wdata;
  assign BranchTaken = r_out_valid && r_taken;
  assign BranchPC    = r_bpc;
  assign Flags       = w_flags;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
module tb_alu_writeback_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid, InReady;
  logic [15:0] REZ, MemData, PCPlus2, BranchTarget, WriteData, BranchPC;
  logic        Zero, Overflow, CarryOut;
  logic [1:0]  WbSel, DestReg, WriteAddr;
  logic        RegWrite, FlagWrite, Branch, BranchNE, Flush, ClearSticky, OutReady;
  logic        OutValid, WriteEn, BranchTaken, StickyOverflow;
  logic [2:0]  Flags;
  logic [7:0]  OverflowCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  alu_writeback_stage dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .REZ(REZ), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
    .MemData(MemData), .PCPlus2(PCPlus2), .WbSel(WbSel), .RegWrite(RegWrite),
    .DestReg(DestReg), .FlagWrite(FlagWrite), .Branch(Branch), .BranchNE(BranchNE),
    .BranchTarget(BranchTarget), .Flush(Flush), .ClearSticky(ClearSticky),
    .OutReady(OutReady), .OutValid(OutValid), .WriteEn(WriteEn),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .BranchTaken(BranchTaken),
    .BranchPC(BranchPC), .Flags(Flags), .StickyOverflow(StickyOverflow),
    .OverflowCount(OverflowCount)
  );

  task automatic idle_inputs();
    InValid = 0; REZ = 0; Zero = 0; Overflow = 0; CarryOut = 0;
    MemData = 0; PCPlus2 = 0; WbSel = 0; RegWrite = 0; DestReg = 0;
    FlagWrite = 0; Branch = 0; BranchNE = 0; BranchTarget = 0;
    Flush = 0; ClearSticky = 0; OutReady = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    repeat (2) @(negedge Clock);
    n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL rst_outvalid got=%0h exp=0", OutValid); end
    n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL rst_inready got=%0h exp=1", InReady); end
    n_cmp++; if (WriteData !== 16'h0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0000", WriteData); end
    n_cmp++; if ({Flags, StickyOverflow, OverflowCount} !== 12'h0) begin n_err++; $display("FAIL rst_flags got=%b/%b/%0d exp=0", Flags, StickyOverflow, OverflowCount); end
    Reset = 0;
  endtask

  task automatic test_basic();
    InValid = 1; REZ = 16'h1234; WbSel = 2'b00; RegWrite = 1; DestReg = 2; OutReady = 1;
    @(negedge Clock);
    n_cmp++; if (OutValid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%0h exp=1", OutValid); end
    n_cmp++; if (WriteEn !== 1'b1) begin n_err++; $display("FAIL basic_we got=%0h exp=1", WriteEn); end
    n_cmp++; if (WriteAddr !== 2'd2) begin n_err++; $display("FAIL basic_waddr got=%0d exp=2", WriteAddr); end
    n_cmp++; if (WriteData !== 16'h1234) begin n_err++; $display("FAIL basic_wdata got=%h exp=1234", WriteData); end
    InValid = 0;
    @(negedge Clock);
    n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL basic_drain got=%0h exp=0", OutValid); end
  endtask

  task automatic test_mux();
    InValid = 1; REZ = 16'h1111; MemData = 16'hBEEF; PCPlus2 = 16'h0102;
    WbSel = 2'b01; RegWrite = 1; DestReg = 1;
    @(negedge Clock);
    n_cmp++; if (WriteData !== 16'hBEEF) begin n_err++; $display("FAIL mux_mem got=%h exp=beef", WriteData); end
    WbSel = 2'b10; RegWrite = 0;
    @(negedge Clock);
    n_cmp++; if (WriteData !== 16'h0102) begin n_err++; $display("FAIL mux_pc got=%h exp=0102", WriteData); end
    n_cmp++; if (WriteEn !== 1'b0) begin n_err++; $display("FAIL mux_we_off got=%0h exp=0", WriteEn); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_stall();
    InValid = 1; REZ = 16'hAAAA; WbSel = 0; RegWrite = 1; DestReg = 1; OutReady = 0;
    @(negedge Clock);
    REZ = 16'hBBBB; DestReg = 3;
    #1;
    n_cmp++; if (InReady !== 1'b0) begin n_err++; $display("FAIL stall_inready got=%0h exp=0", InReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      n_cmp++; if ({OutValid, WriteAddr, WriteData} !== {1'b1, 2'd1, 16'hAAAA}) begin n_err++; $display("FAIL stall_hold%0d got=%0h/%0d/%h exp=1/1/aaaa", i, OutValid, WriteAddr, WriteData); end
    end
    OutReady = 1;
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL stall_release got=%0h exp=1", InReady); end
    @(negedge Clock);
    n_cmp++; if ({OutValid, WriteAddr, WriteData} !== {1'b1, 2'd3, 16'hBBBB}) begin n_err++; $display("FAIL stall_next got=%0h/%0d/%h exp=1/3/bbbb", OutValid, WriteAddr, WriteData); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_branch();
    InValid = 1; Branch = 1; BranchNE = 0; Zero = 1; BranchTarget = 16'h0040;
    @(negedge Clock);
    n_cmp++; if (BranchTaken !== 1'b1) begin n_err++; $display("FAIL beq_taken got=%0h exp=1", BranchTaken); end
    n_cmp++; if (BranchPC !== 16'h0040) begin n_err++; $display("FAIL beq_pc got=%h exp=0040", BranchPC); end
    BranchNE = 1;
    @(negedge Clock);
    n_cmp++; if (BranchTaken !== 1'b0) begin n_err++; $display("FAIL bne_taken got=%0h exp=0", BranchTaken); end
    n_cmp++; if (BranchPC !== 16'h0040) begin n_err++; $display("FAIL bne_pc got=%h exp=0040", BranchPC); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_flags();
    InValid = 1; FlagWrite = 1; Overflow = 1; CarryOut = 1; Zero = 0;
    @(negedge Clock);
    n_cmp++; if (Flags !== 3'b110) begin n_err++; $display("FAIL flags_set got=%b exp=110", Flags); end
    n_cmp++; if ({StickyOverflow, OverflowCount} !== {1'b1, 8'd1}) begin n_err++; $display("FAIL flags_sticky got=%0h/%0d exp=1/1", StickyOverflow, OverflowCount); end
    FlagWrite = 1; Overflow = 0; CarryOut = 0; Zero = 1; WbSel = 2'b11;
    @(negedge Clock);
    n_cmp++; if (WriteData !== 16'h0006) begin n_err++; $display("FAIL flags_word got=%h exp=0006", WriteData); end
    n_cmp++; if (Flags !== 3'b001) begin n_err++; $display("FAIL flags_update got=%b exp=001", Flags); end
    FlagWrite = 0; Overflow = 1; WbSel = 0;
    @(negedge Clock);
    n_cmp++; if ({Flags, OverflowCount} !== {3'b001, 8'd1}) begin n_err++; $display("FAIL flags_nowrite got=%b/%0d exp=001/1", Flags, OverflowCount); end
    FlagWrite = 1; Overflow = 1; CarryOut = 0; Zero = 0;
    repeat (300) @(negedge Clock);
    n_cmp++; if (OverflowCount !== 8'd255) begin n_err++; $display("FAIL ovf_saturate got=%0d exp=255", OverflowCount); end
    idle_inputs(); ClearSticky = 1;
    @(negedge Clock);
    n_cmp++; if ({StickyOverflow, OverflowCount} !== {1'b0, 8'd0}) begin n_err++; $display("FAIL clear got=%0h/%0d exp=0/0", StickyOverflow, OverflowCount); end
    n_cmp++; if (Flags !== 3'b100) begin n_err++; $display("FAIL clear_flags got=%b exp=100", Flags); end
    repeat (2) begin
      InValid = 1; FlagWrite = 1; Overflow = 1; ClearSticky = 0;
      @(negedge Clock);
    end
    ClearSticky = 1;
    @(negedge Clock);
    n_cmp++; if ({StickyOverflow, OverflowCount} !== {1'b1, 8'd1}) begin n_err++; $display("FAIL clear_vs_ovf got=%0h/%0d exp=1/1", StickyOverflow, OverflowCount); end
    Flush = 1; CarryOut = 1; Zero = 1;
    @(negedge Clock);
    n_cmp++; if ({Flags, StickyOverflow, OverflowCount} !== {3'b100, 1'b0, 8'd0}) begin n_err++; $display("FAIL clear_flushed got=%b/%0h/%0d exp=100/0/0", Flags, StickyOverflow, OverflowCount); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_flush();
    InValid = 1; REZ = 16'h5555; RegWrite = 1; OutReady = 0;
    @(negedge Clock);
    n_cmp++; if (OutValid !== 1'b1) begin n_err++; $display("FAIL flush_held got=%0h exp=1", OutValid); end
    FlagWrite = 1; Overflow = 0; CarryOut = 1; Zero = 1; Flush = 1;
    #1;
    n_cmp++; if (InReady !== 1'b0) begin n_err++; $display("FAIL flush_inready got=%0h exp=0", InReady); end
    @(negedge Clock);
    n_cmp++; if ({OutValid, WriteEn} !== 2'b00) begin n_err++; $display("FAIL flush_drop got=%b exp=00", {OutValid, WriteEn}); end
    n_cmp++; if (Flags !== 3'b100) begin n_err++; $display("FAIL flush_flags got=%b exp=100", Flags); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_reset_stall();
    InValid = 1; REZ = 16'h7777; RegWrite = 1; DestReg = 3; Branch = 1; Zero = 1;
    BranchTarget = 16'h0088; FlagWrite = 1; Overflow = 1; OutReady = 0;
    @(negedge Clock);
    InValid = 0;
    n_cmp++; if ({OutValid, WriteEn, BranchTaken} !== 3'b111) begin n_err++; $display("FAIL rs_setup got=%b exp=111", {OutValid, WriteEn, BranchTaken}); end
    #2 Reset = 1;
    #1;
    n_cmp++; if ({OutValid, WriteEn, WriteAddr, WriteData, BranchTaken, BranchPC} !== 36'h0) begin n_err++; $display("FAIL rs_outputs got=%0h/%0h/%0d/%h/%0h/%h exp=0", OutValid, WriteEn, WriteAddr, WriteData, BranchTaken, BranchPC); end
    n_cmp++; if ({Flags, StickyOverflow, OverflowCount} !== 12'h0) begin n_err++; $display("FAIL rs_flags got=%b/%0h/%0d exp=0", Flags, StickyOverflow, OverflowCount); end
    n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL rs_inready got=%0h exp=1", InReady); end
    @(negedge Clock);
    idle_inputs(); Reset = 0;
    InValid = 1; REZ = 16'h0F0F; RegWrite = 1; DestReg = 0;
    @(negedge Clock);
    n_cmp++; if ({OutValid, WriteData} !== {1'b1, 16'h0F0F}) begin n_err++; $display("FAIL rs_first_accept got=%0h/%h exp=1/0f0f", OutValid, WriteData); end
    idle_inputs();
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mux();
    test_stall();
    test_branch();
    test_flags();
    test_flush();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
